serial_add_ctrl: RTL

//   Bit-serial add/subtract sequencer for the ALU. Time-shares one full-adder slice
//   (two halfadder cells plus an OR) over WIDTH cycles, LSB first, instead of a WIDTH-bit

---
 rtl/serial_add_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder slice reused over WIDTH cycles, LSB first,
// with valid/ready request and response handshakes and one operation in flight.
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] sh_a_r;
    logic [WIDTH-1:0] sh_b_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] result_nx_s;
    logic [CW-1:0]    cnt_r;
    logic             cy_r;
    logic             carry_r;
    logic             ovf_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             busy_r;
    logic             last_s;
    logic             hs1_s;
    logic             hc1_s;
    logic             hc2_s;
    logic             sum_s;
    logic             cout_s;

    assign last_s = (cnt_r == CW'(WIDTH - 1));

    // Full-adder slice built from two half adders and an OR, plus the result shift-in.
    always_comb begin
        hs1_s       = sh_a_r[0] ^ sh_b_r[0];
        hc1_s       = sh_a_r[0] & sh_b_r[0];
        sum_s       = hs1_s ^ cy_r;
        hc2_s       = hs1_s & cy_r;
        cout_s      = hc1_s | hc2_s;
        result_nx_s = result_r >> 1;
        result_nx_s[WIDTH-1] = sum_s;
    end

    // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and handshake flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == IDLE);
            rsp_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end

    // Operand capture on accept, then one bit per RUN cycle; carry into the MSB is cy_r on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a_r   <= {WIDTH{1'b0}};
            sh_b_r   <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            cy_r     <= 1'b0;
            carry_r  <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        sh_a_r <= op_a;
                        sh_b_r <= op_sub ? ~op_b : op_b;
                        cy_r   <= op_sub;
                        cnt_r  <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    result_r <= result_nx_s;
                    sh_a_r   <= sh_a_r >> 1;
                    sh_b_r   <= sh_b_r >> 1;
                    cy_r     <= cout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        carry_r <= cout_s;
                        ovf_r   <= cy_r ^ cout_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;
    assign carry_out = carry_r;
    assign overflow  = ovf_r;

endmodule
